icache_refill: RTL and testbench
================================

ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of Pc_in and mem_addr.
REQ-002 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line; power of two, 2..16.
REQ-003 SHALL have parameter NUM_LINES, default 32, direct-mapped line count; power of two, 2..256.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port Pc_in  input  ADDR_W  fetch byte address.
REQ-007 SHALL have port Rd_en  input  1  fetch request; sampled only when Busy=0.
REQ-008 SHALL have port Flush  input  1  invalidate all lines.
REQ-009 SHALL have port Dout  output  32*LINE_WORDS  cache line; word 0 in the MSBs.
REQ-010 SHALL have port Dout_valid  output  1  one-cycle pulse; Dout valid for the last accepted Rd_en.
REQ-011 SHALL have port Busy  output  1  high while a refill is in progress; Rd_en ignored.
REQ-012 SHALL have port mem_req  output  1  refill word request, held until mem_ack.
REQ-013 SHALL have port mem_addr  output  ADDR_W  word-aligned byte address of the requested word.
REQ-014 SHALL have port mem_ack  input  1  mem_rdata valid; completes the current word.
REQ-015 SHALL have port mem_rdata  input  32  refill word.

Function
REQ-016 SHALL split Pc_in into offset [OFF_W-1:0] (OFF_W=log2(LINE_WORDS)+2), index [OFF_W+IDX_W-1:OFF_W] (IDX_W=log2(NUM_LINES)) and tag (remaining MSBs); offset bits are ignored for lookup.
REQ-017 SHALL hold per-line storage: valid bit, tag, LINE_WORDS data words.
REQ-018 SHALL implement FSM IDLE -> REFILL -> RESP -> IDLE.
REQ-019 In IDLE, on Rd_en=1 with a hit (valid and tag equal), SHALL drive Dout = line and Dout_valid=1 on the next cycle; FSM stays in IDLE, so back-to-back hits run at one per cycle.
REQ-020 In IDLE, on Rd_en=1 with a miss, SHALL latch tag and index, enter REFILL and assert Busy next cycle.
REQ-021 In REFILL, SHALL request words 0..LINE_WORDS-1 in order, with mem_addr = {tag, index, word count, 2'b00}, one outstanding request at a time.
REQ-022 SHALL write mem_rdata into the word slot on each cycle where mem_req and mem_ack are both 1, then advance the word count; mem_ack with mem_req=0 SHALL be ignored.
REQ-023 On the last word's ack, SHALL set the line's valid bit and tag and enter RESP.
REQ-024 In RESP, SHALL assert Dout_valid=1 with the refilled line, deassert Busy and return to IDLE; total miss latency is 2 cycles plus the memory time.
REQ-025 Flush in IDLE SHALL clear all valid bits at the clock edge; a simultaneous Rd_en SHALL be treated as a miss.
REQ-026 Flush during REFILL or RESP SHALL be latched; the refill completes and its response is delivered, then all valid bits are cleared on the first IDLE cycle.
REQ-027 Dout SHALL hold its last value while Dout_valid=0.

Reset
REQ-028 Reset SHALL asynchronously force: FSM=IDLE, all valid bits=0, Busy=0, Dout_valid=0, mem_req=0, mem_addr=0, Dout=0, word count=0, pending flush=0.
REQ-029 Reset mid-refill SHALL abandon the refill; the partially written line SHALL remain invalid.
REQ-030 Tag and data arrays SHALL NOT be reset.

Configuration
REQ-031 With ICACHE_STATS_EN defined, SHALL add outputs hit_cnt and miss_cnt (32 bits each, reset to 0, saturating at all-ones), counting accepted hits and misses; without it, these ports and their logic SHALL be absent.

Structure
REQ-032 A shared package SHALL hold the FSM state encodings, the line-address field-width functions and the 32-bit word width constant.
REQ-033 One sub-module, icache_tag_ram (valid bits, tags, hit compare, flush clear), SHALL be instantiated; the data array stays in the top level.

Verification (LINE_WORDS=4, NUM_LINES=32)
REQ-034 Cold miss: Rd_en with Pc_in=0x40 -> mem_addr 0x40, 0x44, 0x48, 0x4C in order; after the 4th ack, one Dout_valid pulse with Dout={w0,w1,w2,w3}.
REQ-035 Hit: then Rd_en with Pc_in=0x44 -> Dout_valid next cycle, same line, mem_req stays 0.
REQ-036 Conflict: Rd_en with Pc_in=0x240 (index 4, new tag) -> refill from 0x240; a following read of 0x40 misses again.
REQ-037 Flush: Flush pulse during the 0x240 refill -> response still delivered; the next Rd_en of 0x240 misses.
REQ-038 Reset after the 2nd ack of a refill of 0x80 -> all outputs 0; the next Rd_en of 0x80 starts a fresh refill at mem_addr 0x80.
REQ-039 Memory stall: hold mem_ack=0 for 10 cycles -> mem_req and mem_addr stay stable and Busy stays 1; a Rd_en asserted during the stall is ignored.

Source files
------------

// File: rtl/icache_refill_pkg.sv
// ============================================================================
// Module   : icache_refill_pkg
// Purpose  : Shared FSM encodings, word width and line-address field widths
//            for the instruction-cache refill block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_refill_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Byte-offset field: word select plus the two byte bits.
  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_words, input int num_lines);
    return addr_w - off_w(line_words) - idx_w(num_lines);
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_tag_ram.sv
// ============================================================================
// Module   : icache_tag_ram
// Purpose  : Valid bits and tags of the direct-mapped cache, hit compare and
//            whole-cache invalidation. Only valid bits are reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_tag_ram #(
  parameter int NUM_LINES = 32,
  parameter int IDX_W     = 5,
  parameter int TAG_W     = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_lk_idx,
  input  logic [TAG_W-1:0] i_lk_tag,
  output logic             o_hit,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic             i_flush
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tags [NUM_LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tags[i_wr_idx] <= i_wr_tag;
    end
  end

  assign o_hit = r_valid[i_lk_idx] && (r_tags[i_lk_idx] == i_lk_tag);

endmodule

`default_nettype wire

// File: rtl/icache_refill.sv
// ============================================================================
// Module   : icache_refill
// Purpose  : Direct-mapped instruction cache with single-outstanding word
//            refill. Optional hit/miss counters under ICACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            Pc_in,
  input  logic                         Rd_en,
  input  logic                         Flush,
  output logic [WORD_W*LINE_WORDS-1:0] Dout,
  output logic                         Dout_valid,
  output logic                         Busy,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_ack,
  input  logic [WORD_W-1:0]            mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]                  hit_cnt,
  output logic [31:0]                  miss_cnt
`endif
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(NUM_LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINE_WORDS, NUM_LINES);
  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

  state_t           r_state;
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_flush_pend;

  logic [WORD_W-1:0] r_data [NUM_LINES][LINE_WORDS];

  logic [IDX_W-1:0]             w_pc_idx;
  logic [TAG_W-1:0]             w_pc_tag;
  logic [IDX_W-1:0]             w_rd_idx;
  logic [CNT_W-1:0]             w_cnt_nxt;
  logic [WORD_W*LINE_WORDS-1:0] w_line;
  logic                         w_hit_raw;
  logic                         w_flush_now;
  logic                         w_accept;
  logic                         w_hit;
  logic                         w_miss;
  logic                         w_fill_we;
  logic                         w_last;
  logic                         w_unused_off;

  assign w_pc_idx     = Pc_in[OFF_W+IDX_W-1:OFF_W];
  assign w_pc_tag     = Pc_in[ADDR_W-1:OFF_W+IDX_W];
  assign w_unused_off = ^Pc_in[OFF_W-1:0];

  // A pending flush from a refill takes effect on the first idle cycle and,
  // like a direct Flush, makes any same-cycle lookup a miss.
  assign w_flush_now = (r_state == ST_IDLE) && (Flush || r_flush_pend);
  assign w_accept    = (r_state == ST_IDLE) && Rd_en;
  assign w_hit       = w_accept && w_hit_raw && !w_flush_now;
  assign w_miss      = w_accept && !(w_hit_raw && !w_flush_now);
  assign w_fill_we   = (r_state == ST_REFILL) && mem_req && mem_ack;
  assign w_last      = (r_cnt == LAST_CNT);
  assign w_cnt_nxt   = r_cnt + 1'b1;
  assign w_rd_idx    = (r_state == ST_IDLE) ? w_pc_idx : r_idx;

  icache_tag_ram #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_tag_ram (
    .clk      (clk),
    .rst      (reset),
    .i_lk_idx (w_pc_idx),
    .i_lk_tag (w_pc_tag),
    .o_hit    (w_hit_raw),
    .i_wr_en  (w_fill_we && w_last),
    .i_wr_idx (r_idx),
    .i_wr_tag (r_tag),
    .i_flush  (w_flush_now)
  );

  // Word 0 lands in the most significant slice of the line.
  always_comb begin
    w_line = '0;
    for (int w = 0; w < LINE_WORDS; w++) begin
      w_line[WORD_W*(LINE_WORDS-w)-1 -: WORD_W] = r_data[w_rd_idx][w];
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_data[r_idx][r_cnt] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_tag        <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      Dout         <= '0;
      Dout_valid   <= 1'b0;
      Busy         <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
    end else begin
      Dout_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_flush_pend <= 1'b0;
          if (w_hit) begin
            Dout       <= w_line;
            Dout_valid <= 1'b1;
          end else if (w_miss) begin
            r_tag    <= w_pc_tag;
            r_idx    <= w_pc_idx;
            r_cnt    <= '0;
            mem_req  <= 1'b1;
            mem_addr <= {w_pc_tag, w_pc_idx, {CNT_W{1'b0}}, 2'b00};
            Busy     <= 1'b1;
            r_state  <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (Flush) begin
            r_flush_pend <= 1'b1;
          end
          if (w_fill_we) begin
            if (w_last) begin
              mem_req <= 1'b0;
              r_cnt   <= '0;
              r_state <= ST_RESP;
            end else begin
              r_cnt    <= w_cnt_nxt;
              mem_addr <= {r_tag, r_idx, w_cnt_nxt, 2'b00};
            end
          end
        end
        ST_RESP: begin
          if (Flush) begin
            r_flush_pend <= 1'b1;
          end
          Dout       <= w_line;
          Dout_valid <= 1'b1;
          Busy       <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (w_hit && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (w_miss && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_refill.sv
// ============================================================================
// Module   : tb_icache_refill
// Purpose  : Self-checking bench for icache_refill against a line-level
//            cache/memory reference model with randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_refill;

  localparam int AW = 32;
  localparam int LW = 4;
  localparam int NL = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] Pc_in;
  logic          Rd_en;
  logic          Flush;
  logic [127:0]  Dout;
  logic          Dout_valid;
  logic          Busy;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
`ifdef ICACHE_STATS_EN
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;
`endif

  always #5 clk = ~clk;

  icache_refill #(
    .ADDR_W     (AW),
    .LINE_WORDS (LW),
    .NUM_LINES  (NL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Pc_in      (Pc_in),
    .Rd_en      (Rd_en),
    .Flush      (Flush),
    .Dout       (Dout),
    .Dout_valid (Dout_valid),
    .Busy       (Busy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  int           checks   = 0;
  int           failures = 0;
  bit           m_valid [NL];
  logic [22:0]  m_tag   [NL];
  int           m_hits;
  int           m_misses;
  logic [127:0] m_last_dout;
  logic [31:0]  seed;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Backing memory: a fixed pseudo-random word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ seed;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:4], 4'h0};
    return {mem_word(b), mem_word(b + 32'd4), mem_word(b + 32'd8), mem_word(b + 32'd12)};
  endfunction

  task automatic model_flush();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  // One fetch; stall < 0 picks a random per-word ack delay of 0..3 cycles.
  task automatic do_read(input logic [31:0] a, input bit fl_in, input bit fl_mid,
                         input int stall, input bit stray);
    int          idx;
    logic [22:0] tg;
    logic [31:0] base;
    bit          hit;
    int          ns;
    idx  = int'(a[8:4]);
    tg   = a[31:9];
    base = {a[31:4], 4'h0};
    @(negedge clk);
    check("idle_busy", Busy, 0);
    check("idle_dv", Dout_valid, 0);
    check("dout_hold", Dout, m_last_dout);
    Pc_in = a;
    Rd_en = 1'b1;
    Flush = fl_in;
    if (fl_in) model_flush();
    hit = m_valid[idx] && (m_tag[idx] == tg);
    @(negedge clk);
    Rd_en = 1'b0;
    Flush = 1'b0;
    if (hit) begin
      m_hits++;
      check("hit_dv", Dout_valid, 1);
      check("hit_dout", Dout, mem_line(a));
      check("hit_req", mem_req, 0);
      check("hit_busy", Busy, 0);
      m_last_dout = mem_line(a);
    end else begin
      m_misses++;
      check("miss_dv", Dout_valid, 0);
      check("miss_busy", Busy, 1);
      for (int w = 0; w < LW; w++) begin
        ns = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        for (int s = 0; s < ns; s++) begin
          check("stall_req", mem_req, 1);
          check("stall_addr", mem_addr, base + 32'(4 * w));
          check("stall_busy", Busy, 1);
          check("stall_dv", Dout_valid, 0);
          if (stray) begin
            Rd_en = 1'b1;
            Pc_in = $urandom;
          end
          @(negedge clk);
        end
        Rd_en = 1'b0;
        check("req", mem_req, 1);
        check("addr", mem_addr, base + 32'(4 * w));
        mem_ack   = 1'b1;
        mem_rdata = mem_word(base + 32'(4 * w));
        if (fl_mid && (w == 1)) Flush = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        Flush   = 1'b0;
      end
      check("resp_dv", Dout_valid, 0);
      check("resp_busy", Busy, 1);
      check("resp_req", mem_req, 0);
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      @(negedge clk);
      mem_ack = 1'b0;
      check("fill_dv", Dout_valid, 1);
      check("fill_dout", Dout, mem_line(a));
      check("fill_busy", Busy, 0);
      check("fill_req", mem_req, 0);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      if (fl_mid) model_flush();
      m_last_dout = mem_line(a);
    end
  endtask

  task automatic hit_burst(input logic [31:0] a0, input logic [31:0] a1);
    @(negedge clk);
    Pc_in = a0;
    Rd_en = 1'b1;
    @(negedge clk);
    check("burst0_dv", Dout_valid, 1);
    check("burst0_dout", Dout, mem_line(a0));
    Pc_in = a1;
    @(negedge clk);
    Rd_en = 1'b0;
    check("burst1_dv", Dout_valid, 1);
    check("burst1_dout", Dout, mem_line(a1));
    m_hits += 2;
    m_last_dout = mem_line(a1);
  endtask

  initial begin
    logic [31:0] a;
    seed      = $urandom;
    reset     = 1'b1;
    Pc_in     = '0;
    Rd_en     = 1'b0;
    Flush     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    model_flush();
    m_hits      = 0;
    m_misses    = 0;
    m_last_dout = '0;
    repeat (2) @(negedge clk);
    check("rst_dout", Dout, 0);
    check("rst_dv", Dout_valid, 0);
    check("rst_busy", Busy, 0);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    reset = 1'b0;

    do_read(32'h40, 0, 0, 0, 0);
    do_read(32'h44, 0, 0, 0, 0);
    hit_burst(32'h40, 32'h4C);
    do_read(32'h240, 0, 0, -1, 0);
    do_read(32'h40, 0, 0, -1, 0);
    do_read(32'h240, 0, 1, -1, 0);
    do_read(32'h240, 0, 0, -1, 0);
    do_read(32'h300, 0, 0, 10, 1);
    do_read(32'h304, 0, 0, 0, 0);
    do_read(32'h308, 1, 0, 0, 0);

    // Abandon a refill of 0x80 after its second ack.
    @(negedge clk);
    Pc_in = 32'h80;
    Rd_en = 1'b1;
    @(negedge clk);
    Rd_en = 1'b0;
    for (int w = 0; w < 2; w++) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_0000 | 32'(w);
      @(negedge clk);
      mem_ack = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    check("arst_dout", Dout, 0);
    check("arst_dv", Dout_valid, 0);
    check("arst_busy", Busy, 0);
    check("arst_req", mem_req, 0);
    check("arst_addr", mem_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    model_flush();
    m_hits      = 0;
    m_misses    = 0;
    m_last_dout = '0;
    do_read(32'h80, 0, 0, -1, 0);
    do_read(32'h8C, 0, 0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
      do_read(a, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), -1,
              ($urandom_range(0, 3) == 0));
    end

`ifdef ICACHE_STATS_EN
    @(negedge clk);
    check("hit_cnt", hit_cnt, 32'(m_hits));
    check("miss_cnt", miss_cnt, 32'(m_misses));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
